// File: rtl/fifo_wr_sched_if.sv
// Bundle between the FIFO write scheduler, its requesters and the FIFO write port.
// The scheduler connects through the slave modport.
interface fifo_wr_sched_if #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 2
);
  localparam int IDW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]              REQ_VALID;
  logic [NUM_REQ*2*DATA_WIDTH-1:0] REQ_DATA;
  logic [NUM_REQ-1:0]              REQ_TWO_BYTE;
  logic [NUM_REQ-1:0]              REQ_ACK;
  logic                            FIFO_FULL;
  logic                            FIFO_W_INC;
  logic [DATA_WIDTH-1:0]           FIFO_WR_DATA;
  logic [IDW-1:0]                  GRANT_ID;
  logic                            BUSY;

  modport master (
    output REQ_VALID, REQ_DATA, REQ_TWO_BYTE, FIFO_FULL,
    input  REQ_ACK, FIFO_W_INC, FIFO_WR_DATA, GRANT_ID, BUSY
  );

  modport slave (
    input  REQ_VALID, REQ_DATA, REQ_TWO_BYTE, FIFO_FULL,
    output REQ_ACK, FIFO_W_INC, FIFO_WR_DATA, GRANT_ID, BUSY
  );
endinterface

// File: rtl/fifo_wr_sched.sv
// Round-robin write scheduler for the async FIFO write port (W_CLK domain).
// Each granted 1- or 2-byte frame is written as one uninterrupted burst that honours FIFO_FULL.
module fifo_wr_sched #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 2
) (
  input  logic             W_CLK,
  input  logic             W_RST,
  fifo_wr_sched_if.slave   bus
);
  localparam int IDW = $clog2(NUM_REQ);
  localparam int FW  = 2 * DATA_WIDTH;
  localparam logic [NUM_REQ-1:0] ACK_ONE = {{(NUM_REQ-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEND_LO = 2'd1,
    SEND_HI = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_s;
  logic [IDW-1:0]   ptr_r;
  logic [IDW-1:0]   grant_r;
  logic [FW-1:0]    frame_r;
  logic             two_r;
  logic [IDW-1:0]   win_s;
  logic             found_s;
  logic             grant_s;
  logic [NUM_REQ-1:0] ack_s;
  logic             inc_s;
  logic [DATA_WIDTH-1:0] wr_data_s;

  // Round-robin pick: scan from farthest to nearest so the nearest set bit after ptr_r wins.
  always_comb begin
    logic [IDW-1:0] idx;
    win_s   = '0;
    found_s = 1'b0;
    idx     = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx     = IDW'((int'(ptr_r) + k) % NUM_REQ);
      found_s = found_s | bus.REQ_VALID[idx];
      win_s   = bus.REQ_VALID[idx] ? idx : win_s;
    end
  end

  // Next state, grant pulse and write strobe; ACK is held off while W_RST is asserted.
  always_comb begin
    state_s = state_r;
    grant_s = 1'b0;
    ack_s   = '0;
    inc_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (found_s && W_RST) begin
          grant_s = 1'b1;
          ack_s   = ACK_ONE << win_s;
          state_s = SEND_LO;
        end else begin
          state_s = IDLE;
        end
      end
      SEND_LO: begin
        inc_s = ~bus.FIFO_FULL;
        if (!bus.FIFO_FULL) begin
          state_s = two_r ? SEND_HI : IDLE;
        end else begin
          state_s = SEND_LO;
        end
      end
      SEND_HI: begin
        inc_s = ~bus.FIFO_FULL;
        if (!bus.FIFO_FULL) begin
          state_s = IDLE;
        end else begin
          state_s = SEND_HI;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Byte select straight from the frame register so the data path never touches the strobe.
  always_comb begin
    case (state_r)
      SEND_HI: wr_data_s = frame_r[FW-1:DATA_WIDTH];
      default: wr_data_s = frame_r[DATA_WIDTH-1:0];
    endcase
  end

  // State, round-robin pointer and latched frame.
  always_ff @(posedge W_CLK or negedge W_RST) begin
    if (!W_RST) begin
      state_r <= IDLE;
      ptr_r   <= IDW'(NUM_REQ - 1);
      grant_r <= '0;
      frame_r <= '0;
      two_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      if (grant_s) begin
        ptr_r   <= win_s;
        grant_r <= win_s;
        frame_r <= bus.REQ_DATA[int'(win_s)*FW +: FW];
        two_r   <= bus.REQ_TWO_BYTE[win_s];
      end
    end
  end

  assign bus.REQ_ACK      = ack_s;
  assign bus.FIFO_W_INC   = inc_s;
  assign bus.FIFO_WR_DATA = wr_data_s;
  assign bus.GRANT_ID     = grant_r;
  assign bus.BUSY         = (state_r != IDLE);
endmodule

// File: tb/tb_fifo_wr_sched.sv
// Directed, table-driven bench for fifo_wr_sched (2 requesters, 8-bit data).
module tb_fifo_wr_sched;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;

  fifo_wr_sched_if #(.DATA_WIDTH(8), .NUM_REQ(2)) bus ();

  fifo_wr_sched #(.DATA_WIDTH(8), .NUM_REQ(2)) dut (
    .W_CLK (clk),
    .W_RST (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        rst;
    logic [1:0]  valid;
    logic [31:0] data;
    logic [1:0]  two;
    logic        full;
    logic [1:0]  ack;
    logic        inc;
    logic [7:0]  wdata;
    logic        busy;
    logic        gid;
  } vec_t;

  function automatic vec_t mk(input logic rst, input logic [1:0] valid, input logic [31:0] data,
                              input logic [1:0] two, input logic full, input logic [1:0] ack,
                              input logic inc, input logic [7:0] wdata, input logic busy,
                              input logic gid);
    vec_t v;
    v.rst = rst; v.valid = valid; v.data = data; v.two = two; v.full = full;
    v.ack = ack; v.inc = inc; v.wdata = wdata; v.busy = busy; v.gid = gid;
    return v;
  endfunction

  task automatic check(input string name, input int n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, n, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] valid, input logic [31:0] data, input logic [1:0] two,
                       input logic full);
    bus.REQ_VALID    = valid;
    bus.REQ_DATA     = data;
    bus.REQ_TWO_BYTE = two;
    bus.FIFO_FULL    = full;
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive(2'b00, 32'h0, 2'b00, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic apply(input vec_t v, input int n);
    if (v.rst) do_reset();
    @(negedge clk);
    drive(v.valid, v.data, v.two, v.full);
    #2;
    check("ack",  n, 32'(bus.REQ_ACK),    32'(v.ack));
    check("winc", n, 32'(bus.FIFO_W_INC), 32'(v.inc));
    check("busy", n, 32'(bus.BUSY),       32'(v.busy));
    check("gid",  n, 32'(bus.GRANT_ID),   32'(v.gid));
    if (v.inc) check("wdata", n, 32'(bus.FIFO_WR_DATA), 32'(v.wdata));
  endtask

  initial begin
    vec_t tv[$];
    drive(2'b00, 32'h0, 2'b00, 1'b0);
    // Round-robin: both valid, one byte each, req0 first after reset.
    tv.push_back(mk(1'b1, 2'b11, 32'h0022_0011, 2'b00, 1'b0, 2'b01, 1'b0, 8'h00, 1'b0, 1'b0));
    tv.push_back(mk(1'b0, 2'b11, 32'h0022_0011, 2'b00, 1'b0, 2'b00, 1'b1, 8'h11, 1'b1, 1'b0));
    tv.push_back(mk(1'b0, 2'b11, 32'h0022_0011, 2'b00, 1'b0, 2'b10, 1'b0, 8'h00, 1'b0, 1'b0));
    tv.push_back(mk(1'b0, 2'b11, 32'h0022_0011, 2'b00, 1'b0, 2'b00, 1'b1, 8'h22, 1'b1, 1'b1));
    tv.push_back(mk(1'b0, 2'b11, 32'h0022_0011, 2'b00, 1'b0, 2'b01, 1'b0, 8'h00, 1'b0, 1'b1));
    tv.push_back(mk(1'b0, 2'b11, 32'h0022_0011, 2'b00, 1'b0, 2'b00, 1'b1, 8'h11, 1'b1, 1'b0));
    tv.push_back(mk(1'b0, 2'b11, 32'h0022_0011, 2'b00, 1'b0, 2'b10, 1'b0, 8'h00, 1'b0, 1'b0));
    tv.push_back(mk(1'b0, 2'b11, 32'h0022_0011, 2'b00, 1'b0, 2'b00, 1'b1, 8'h22, 1'b1, 1'b1));
    // Reset, then a single 2-byte frame A55A.
    tv.push_back(mk(1'b1, 2'b01, 32'h0000_A55A, 2'b01, 1'b0, 2'b01, 1'b0, 8'h00, 1'b0, 1'b0));
    tv.push_back(mk(1'b0, 2'b00, 32'h0000_A55A, 2'b01, 1'b0, 2'b00, 1'b1, 8'h5A, 1'b1, 1'b0));
    tv.push_back(mk(1'b0, 2'b00, 32'h0000_A55A, 2'b01, 1'b0, 2'b00, 1'b1, 8'hA5, 1'b1, 1'b0));
    tv.push_back(mk(1'b0, 2'b00, 32'h0000_A55A, 2'b01, 1'b0, 2'b00, 1'b0, 8'h00, 1'b0, 1'b0));
    // FIFO_FULL for 4 cycles while in SEND_HI.
    tv.push_back(mk(1'b0, 2'b01, 32'h0000_C3B4, 2'b01, 1'b0, 2'b01, 1'b0, 8'h00, 1'b0, 1'b0));
    tv.push_back(mk(1'b0, 2'b00, 32'h0000_C3B4, 2'b01, 1'b0, 2'b00, 1'b1, 8'hB4, 1'b1, 1'b0));
    for (int i = 0; i < 4; i++)
      tv.push_back(mk(1'b0, 2'b00, 32'h0000_C3B4, 2'b01, 1'b1, 2'b00, 1'b0, 8'h00, 1'b1, 1'b0));
    tv.push_back(mk(1'b0, 2'b00, 32'h0000_C3B4, 2'b01, 1'b0, 2'b00, 1'b1, 8'hC3, 1'b1, 1'b0));
    tv.push_back(mk(1'b0, 2'b00, 32'h0000_C3B4, 2'b01, 1'b0, 2'b00, 1'b0, 8'h00, 1'b0, 1'b0));
    // req1 raises during req0's 2-byte frame; it is acked only in the next IDLE cycle.
    tv.push_back(mk(1'b0, 2'b01, 32'h0099_3412, 2'b01, 1'b0, 2'b01, 1'b0, 8'h00, 1'b0, 1'b0));
    tv.push_back(mk(1'b0, 2'b11, 32'h0099_3412, 2'b01, 1'b0, 2'b00, 1'b1, 8'h12, 1'b1, 1'b0));
    tv.push_back(mk(1'b0, 2'b11, 32'h0099_3412, 2'b01, 1'b0, 2'b00, 1'b1, 8'h34, 1'b1, 1'b0));
    tv.push_back(mk(1'b0, 2'b10, 32'h0099_3412, 2'b01, 1'b0, 2'b10, 1'b0, 8'h00, 1'b0, 1'b0));
    tv.push_back(mk(1'b0, 2'b00, 32'h0099_3412, 2'b01, 1'b0, 2'b00, 1'b1, 8'h99, 1'b1, 1'b1));
    tv.push_back(mk(1'b0, 2'b00, 32'h0099_3412, 2'b01, 1'b0, 2'b00, 1'b0, 8'h00, 1'b0, 1'b1));
    // Data changes to FF right after the ack; latched 7856 must still go out.
    tv.push_back(mk(1'b0, 2'b01, 32'h0000_7856, 2'b01, 1'b0, 2'b01, 1'b0, 8'h00, 1'b0, 1'b1));
    tv.push_back(mk(1'b0, 2'b00, 32'h0000_FFFF, 2'b01, 1'b0, 2'b00, 1'b1, 8'h56, 1'b1, 1'b0));
    tv.push_back(mk(1'b0, 2'b00, 32'h0000_FFFF, 2'b01, 1'b0, 2'b00, 1'b1, 8'h78, 1'b1, 1'b0));
    tv.push_back(mk(1'b0, 2'b00, 32'h0000_FFFF, 2'b01, 1'b0, 2'b00, 1'b0, 8'h00, 1'b0, 1'b0));

    // Power-on reset state.
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #2;
    check("rst_ack",   0, 32'(bus.REQ_ACK),      32'h0);
    check("rst_winc",  0, 32'(bus.FIFO_W_INC),   32'h0);
    check("rst_busy",  0, 32'(bus.BUSY),         32'h0);
    check("rst_gid",   0, 32'(bus.GRANT_ID),     32'h0);
    check("rst_wdata", 0, 32'(bus.FIFO_WR_DATA), 32'h0);

    for (int i = 0; i < tv.size(); i++) apply(tv[i], i + 1);

    // Reset during SEND_HI; pointer was 0 so without reset req1 would win next.
    @(negedge clk);
    drive(2'b01, 32'h0000_BEEF, 2'b01, 1'b0);
    #2; check("mr_ack", 100, 32'(bus.REQ_ACK), 32'h1);
    @(negedge clk);
    drive(2'b00, 32'h0000_BEEF, 2'b01, 1'b0);
    #2; check("mr_lo", 101, 32'(bus.FIFO_WR_DATA), 32'hEF);
    @(negedge clk);
    #1; check("mr_hi_busy", 102, 32'(bus.BUSY), 32'h1);
    drive(2'b11, 32'h0066_0055, 2'b00, 1'b0);
    rst_n = 1'b0;
    #1;
    check("mr_winc", 103, 32'(bus.FIFO_W_INC), 32'h0);
    check("mr_busy", 103, 32'(bus.BUSY),       32'h0);
    check("mr_noack", 103, 32'(bus.REQ_ACK),   32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #2; check("mr_prio", 104, 32'(bus.REQ_ACK), 32'h1);
    @(negedge clk);
    drive(2'b00, 32'h0066_0055, 2'b00, 1'b0);
    #2;
    check("mr_winc2", 105, 32'(bus.FIFO_W_INC),   32'h1);
    check("mr_data2", 105, 32'(bus.FIFO_WR_DATA), 32'h55);
    @(negedge clk);
    #2;
    check("mr_winc3", 106, 32'(bus.FIFO_W_INC), 32'h0);
    check("mr_busy3", 106, 32'(bus.BUSY),       32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
